// File: rtl/sbox_inv_hpc2_ctrl_d2_pkg.sv
// Shared definitions for the masked inverse Skinny-64 S-box.
// Holds share/randomness dimensions, the fixed result latency, the control
// FSM state type and an unmasked S4inv reference (for models only).
package sbox_inv_hpc2_ctrl_d2_pkg;

    localparam int unsigned NUM_SHARES    = 3;
    localparam int unsigned FRESH_PER_AND = 3;
    localparam int unsigned NUM_AND       = 4;
    localparam int unsigned LATENCY       = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Unmasked reference; never instantiated in the datapath.
    function automatic logic [3:0] s4inv(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h3;  4'h1: y = 4'h4;  4'h2: y = 4'h6;  4'h3: y = 4'h8;
            4'h4: y = 4'hC;  4'h5: y = 4'hA;  4'h6: y = 4'h1;  4'h7: y = 4'hE;
            4'h8: y = 4'h9;  4'h9: y = 4'h2;  4'hA: y = 4'h5;  4'hB: y = 4'h7;
            4'hC: y = 4'h0;  4'hD: y = 4'hB;  4'hE: y = 4'hD;  default: y = 4'hF;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/and_HPC2.sv
// HPC2 masked AND gadget, 2-cycle latency.
// Ports: clk, rst_n (async active-low), a/b (shares, a must stay stable for
// both cycles, b is sampled in the first), r (one fresh bit per share pair),
// c (shares of a&b, valid two edges after b is sampled).
module and_HPC2 #(
    parameter int security_order = 2
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic [security_order:0]                       a,
    input  logic [security_order:0]                       b,
    input  logic [(security_order+1)*security_order/2-1:0] r,
    output logic [security_order:0]                       c
);
    localparam int unsigned N = security_order + 1;

    // Index of the fresh bit shared by pair (i,j), symmetric in i and j.
    function automatic int unsigned ridx(input int unsigned i, input int unsigned j);
        int unsigned lo, hi;
        lo = (i < j) ? i : j;
        hi = (i < j) ? j : i;
        return lo * N - (lo * (lo + 1)) / 2 + (hi - lo - 1);
    endfunction

    logic [N-1:0]         rb, ab;
    logic [N-1:0][N-1:0]  rr, rs, u, v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rb <= '0;
            ab <= '0;
            rr <= '0;
            rs <= '0;
            u  <= '0;
            v  <= '0;
        end else begin
            rb <= b;
            ab <= a & rb;
            for (int unsigned i = 0; i < N; i++) begin
                for (int unsigned j = 0; j < N; j++) begin
                    if (i != j) begin
                        rr[i][j] <= r[ridx(i, j)];
                        rs[i][j] <= b[j] ^ r[ridx(i, j)];
                        // Separate registers keep ~a*r and a*(b+r) from glitching together.
                        u[i][j]  <= ~a[i] & rr[i][j];
                        v[i][j]  <= a[i] & rs[i][j];
                    end
                end
            end
        end
    end

    always_comb begin
        c = ab;
        for (int unsigned i = 0; i < N; i++) begin
            for (int unsigned j = 0; j < N; j++) begin
                if (i != j) c[i] = c[i] ^ u[i][j] ^ v[i][j];
            end
        end
    end

endmodule

// File: rtl/sbox_inv_hpc2_ctrl_d2_fsm.sv
// Control FSM for the masked inverse S-box: IDLE -> BUSY -> DONE -> IDLE.
// Ports: clk, rst_n (async active-low), in_valid/out_ready handshake inputs;
// in_ready, accept (transaction taken this edge), busy, cnt (BUSY cycle
// index), load_so (last BUSY cycle), out_valid, synch (first DONE cycle).
import sbox_inv_hpc2_ctrl_d2_pkg::*;

module sbox_inv_ctrl_fsm #(
    parameter int LATENCY = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic       out_ready,
    output logic       in_ready,
    output logic       accept,
    output logic       busy,
    output logic [2:0] cnt,
    output logic       load_so,
    output logic       out_valid,
    output logic       synch
);
    state_t st;

    assign in_ready  = (st == ST_IDLE);
    assign accept    = in_ready & in_valid;
    assign busy      = (st == ST_BUSY);
    assign load_so   = busy && (cnt == 3'(LATENCY - 1));
    assign out_valid = (st == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st    <= ST_IDLE;
            cnt   <= '0;
            synch <= 1'b0;
        end else begin
            synch <= load_so;
            case (st)
                ST_IDLE: if (in_valid) begin
                    st  <= ST_BUSY;
                    cnt <= '0;
                end
                ST_BUSY: if (load_so) begin
                    st  <= ST_DONE;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 3'd1;
                end
                ST_DONE: if (out_ready) st <= ST_IDLE;
                default: st <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/sbox_inv_hpc2_ctrl_d2.sv
// Masked (d=2, three shares) inverse Skinny-64 4-bit S-box with handshake.
// S4inv = step; 3x(rotate right, step), step being b0 ^= NOR(b3,b2); each
// NOR is an HPC2 AND on share-complemented inputs, gadgets run back to back.
// Ports: clk, rst (async active-low), SI_s0..2 / Fresh / in_valid / in_ready
// input side, SO_s0..2 / out_valid / out_ready / Synch output side.
import sbox_inv_hpc2_ctrl_d2_pkg::*;

module sbox_inv_hpc2_ctrl_d2 #(
    parameter int SECURITY_ORDER = 2,
    parameter int LATENCY        = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  SI_s0,
    input  logic [3:0]  SI_s1,
    input  logic [3:0]  SI_s2,
    input  logic [11:0] Fresh,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [3:0]  SO_s0,
    output logic [3:0]  SO_s1,
    output logic [3:0]  SO_s2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        Synch
);
    typedef logic [NUM_SHARES-1:0][3:0] nib_sh_t;

    nib_sh_t si_sh, s_sh, step_sh, cur_sh, so_q;
    logic [2:0] cnt;
    logic       accept, busy, load_so;
    logic [FRESH_PER_AND*(NUM_AND-1)-1:0] fresh_q;
    logic [NUM_AND-1:0][NUM_SHARES-1:0]    g_a, g_b, g_c;
    logic [NUM_AND-1:0][FRESH_PER_AND-1:0] g_r;
    logic [NUM_SHARES-1:0] c_sel;

    assign si_sh = {SI_s2, SI_s1, SI_s0};

    sbox_inv_ctrl_fsm #(.LATENCY(LATENCY)) u_fsm (
        .clk      (clk),
        .rst_n    (rst),
        .in_valid (in_valid),
        .out_ready(out_ready),
        .in_ready (in_ready),
        .accept   (accept),
        .busy     (busy),
        .cnt      (cnt),
        .load_so  (load_so),
        .out_valid(out_valid),
        .synch    (Synch)
    );

    // Gadget k's product is visible during BUSY cycle 2k+1.
    assign c_sel = g_c[cnt[2:1]];

    // On odd cycles the pending step is folded in and rotated so the next
    // gadget sees the updated nibble one cycle before it is registered.
    always_comb begin
        step_sh = s_sh;
        cur_sh  = s_sh;
        for (int unsigned i = 0; i < NUM_SHARES; i++) begin
            step_sh[i][0] = s_sh[i][0] ^ c_sel[i];
            if (busy && cnt[0]) cur_sh[i] = {step_sh[i][0], step_sh[i][3:1]};
        end
    end

    // Gadget 0 samples SI/Fresh directly on the accepting edge, which is
    // what lets four 2-cycle gadgets fit in eight cycles.
    always_comb begin
        logic [3:0] nib;
        nib = '0;
        g_a = '0;
        g_b = '0;
        g_r = '0;
        g_r[0] = Fresh[2:0];
        for (int unsigned k = 1; k < NUM_AND; k++)
            g_r[k] = fresh_q[FRESH_PER_AND*(k-1) +: FRESH_PER_AND];
        for (int unsigned k = 0; k < NUM_AND; k++) begin
            for (int unsigned i = 0; i < NUM_SHARES; i++) begin
                nib = (k == 0 && in_ready) ? si_sh[i] : cur_sh[i];
                g_a[k][i] = nib[3] ^ (i == 0);
                g_b[k][i] = nib[2] ^ (i == 0);
            end
        end
    end

    for (genvar k = 0; k < NUM_AND; k++) begin : g_and
        and_HPC2 #(.security_order(SECURITY_ORDER)) u_and (
            .clk  (clk),
            .rst_n(rst),
            .a    (g_a[k]),
            .b    (g_b[k]),
            .r    (g_r[k]),
            .c    (g_c[k])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_sh    <= '0;
            fresh_q <= '0;
            so_q    <= '0;
        end else begin
            if (accept) begin
                s_sh    <= si_sh;
                fresh_q <= Fresh[11:3];
            end else if (busy && cnt[0]) begin
                s_sh <= cur_sh;
            end
            if (load_so) so_q <= step_sh;
        end
    end

    assign SO_s0 = so_q[0];
    assign SO_s1 = so_q[1];
    assign SO_s2 = so_q[2];

endmodule

// File: tb/tb_sbox_inv_hpc2_ctrl_d2.sv
// Directed self-checking bench for sbox_inv_hpc2_ctrl_d2.
module tb_sbox_inv_hpc2_ctrl_d2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  SI_s0 = '0, SI_s1 = '0, SI_s2 = '0;
    logic [11:0] Fresh = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  SO_s0, SO_s1, SO_s2;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        Synch;

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0] inv_tab [16] = '{4'h3, 4'h4, 4'h6, 4'h8, 4'hC, 4'hA, 4'h1, 4'hE,
                                 4'h9, 4'h2, 4'h5, 4'h7, 4'h0, 4'hB, 4'hD, 4'hF};
    logic [3:0] r0, r1, xv;

    always #5 clk = ~clk;

    sbox_inv_hpc2_ctrl_d2 #(.SECURITY_ORDER(2), .LATENCY(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .SI_s0    (SI_s0),
        .SI_s1    (SI_s1),
        .SI_s2    (SI_s2),
        .Fresh    (Fresh),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .SO_s0    (SO_s0),
        .SO_s1    (SO_s1),
        .SO_s2    (SO_s2),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .Synch    (Synch)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accept one nibble, wait (bounded) for out_valid, check latency and result.
    // Leaves the bench at the negedge of the first DONE cycle.
    task automatic txn(input logic [3:0] s0, input logic [3:0] s1, input logic [3:0] s2,
                       input logic [3:0] exp, input bit noisy, input string tag);
        int lat;
        @(negedge clk);
        SI_s0 = s0; SI_s1 = s1; SI_s2 = s2;
        Fresh = 12'($urandom);
        in_valid = 1'b1;
        chk({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            chk({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
            if (noisy) begin
                in_valid = 1'($urandom);
                SI_s0 = 4'($urandom); SI_s1 = 4'($urandom); SI_s2 = 4'($urandom);
                Fresh = 12'($urandom);
            end
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        chk({tag, "_latency"}, 32'(lat), 32'd8);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_synch_first"}, 32'(Synch), 32'd1);
        chk({tag, "_in_ready_done"}, 32'(in_ready), 32'd0);
        chk({tag, "_result"}, 32'(SO_s0 ^ SO_s1 ^ SO_s2), 32'(exp));
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_out_valid_drop"}, 32'(out_valid), 32'd0);
        chk({tag, "_back_idle"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        // Reset state
        #2 rst = 1'b0;
        #10;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_synch", 32'(Synch), 32'd0);
        chk("rst_so", 32'({SO_s2, SO_s1, SO_s0}), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;

        // x = 5^A^F = 0 -> 3
        txn(4'h5, 4'hA, 4'hF, 4'h3, 1'b0, "first");
        @(posedge clk);
        @(negedge clk);
        chk("first_synch_once", 32'(Synch), 32'd0);
        consume("first");

        // Full sweep with random share splits
        for (int x = 0; x < 16; x++) begin
            r0 = 4'($urandom);
            r1 = 4'($urandom);
            xv = 4'(x);
            txn(r0, r1, xv ^ r0 ^ r1, inv_tab[x], 1'b0, $sformatf("sweep%0h", x));
            consume($sformatf("sweep%0h", x));
        end

        // Back-pressure: 5 cycles in DONE with out_ready low, x = 7 -> E
        r0 = 4'($urandom);
        r1 = 4'($urandom);
        txn(r0, r1, 4'h7 ^ r0 ^ r1, 4'hE, 1'b0, "hold");
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_synch_low", 32'(Synch), 32'd0);
            chk("hold_result", 32'(SO_s0 ^ SO_s1 ^ SO_s2), 32'hE);
        end
        // Consume while offering new input: the input must not be taken
        SI_s0 = 4'h1; SI_s1 = 4'h2; SI_s2 = 4'h4;
        in_valid = 1'b1;
        consume("collide");
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        chk("collide_no_result", 32'(out_valid), 32'd0);
        chk("collide_still_idle", 32'(in_ready), 32'd1);

        // in_valid noise during BUSY, x = 6 -> 1
        r0 = 4'($urandom);
        r1 = 4'($urandom);
        txn(r0, r1, 4'h6 ^ r0 ^ r1, 4'h1, 1'b1, "noisy");
        consume("noisy");

        // Reset at BUSY cycle 4
        @(negedge clk);
        SI_s0 = 4'h9; SI_s1 = 4'h3; SI_s2 = 4'hC;
        Fresh = 12'($urandom);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_so0", 32'(SO_s0), 32'd0);
        chk("midrst_so1", 32'(SO_s1), 32'd0);
        chk("midrst_so2", 32'(SO_s2), 32'd0);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_synch", 32'(Synch), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        r0 = 4'($urandom);
        r1 = 4'($urandom);
        txn(r0, r1, 4'h8 ^ r0 ^ r1, 4'h9, 1'b0, "after_rst");
        consume("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sbox_inv_hpc2_ctrl_d2.md
SBOX_INV_HPC2_CTRL_D2 -- requirements
Module: sbox_inv_hpc2_ctrl_d2

Interface
REQ-001 SHALL have parameter SECURITY_ORDER, default 2, masking order d; share count = d+1 = 3.
REQ-002 SHALL have parameter LATENCY, default 8, cycles from acceptance to out_valid.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports SI_s0, SI_s1, SI_s2  input  4 each  Boolean shares of the ciphertext nibble.
REQ-006 SHALL have port Fresh  input  12  fresh randomness, 3 bits per AND gadget.
REQ-007 SHALL have port in_valid  input  1  input shares and Fresh valid.
REQ-008 SHALL have port in_ready  output  1  block can accept.
REQ-009 SHALL have ports SO_s0, SO_s1, SO_s2  output  4 each  shares of the inverse S-box result.
REQ-010 SHALL have port out_valid  output  1  SO shares valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port Synch  output  1  one-cycle pulse marking result completion.

Function
REQ-013 SHALL compute, on unmasked values, y = S4inv(x) with S4inv[0..F] = 3,4,6,8,C,A,1,E,9,2,5,7,0,B,D,F, where x = XOR of the SI shares and y = XOR of the SO shares.
REQ-014 SHALL realise S4inv as four sequential NOR-XOR steps, inverting the Skinny-64 forward steps, each step using exactly one 2-cycle HPC2 AND gadget on complemented shares; no unmasked recombination anywhere.
REQ-015 SHALL give gadget k (k=0..3) randomness Fresh[3k+2:3k], registered at acceptance; no Fresh bit is reused across gadgets.
REQ-016 SHALL implement FSM IDLE -> BUSY -> DONE -> IDLE.
REQ-017 IDLE: in_ready=1; in_valid=1 accepts the transaction, registers SI shares and Fresh, clears the cycle counter, and moves to BUSY.
REQ-018 BUSY: in_ready=0; a 3-bit counter increments each cycle; when the counter reaches LATENCY-1, load SO registers and move to DONE.
REQ-019 out_valid SHALL rise exactly LATENCY=8 cycles after the accepting edge.
REQ-020 Synch SHALL be 1 only in the first DONE cycle.
REQ-021 DONE: out_valid=1 and SO held stable until out_ready=1; on that edge move to IDLE and drop out_valid.
REQ-022 DONE and out_ready=1 and in_valid=1 in the same cycle: the result is consumed and the new input is NOT accepted; in_ready=0 throughout DONE.
REQ-023 in_valid asserted in BUSY or DONE SHALL be ignored, with no effect on state or shares.
REQ-024 SO shares SHALL change only on the BUSY->DONE edge and never expose intermediate gadget values.
REQ-025 Counter SHALL never wrap within BUSY; the BUSY->DONE exit is the only path out of BUSY.

Reset
REQ-026 rst=0 SHALL asynchronously force IDLE, counter=0, SO_s0/1/2=0, out_valid=0, Synch=0, in_ready=1 after release, and clear all gadget and share registers.
REQ-027 Reset mid-BUSY or mid-DONE SHALL abort the transaction with no output; the first edge after release behaves as IDLE.

Structure
REQ-028 Shared package SHALL hold the S4inv table (reference model only), NUM_SHARES, FRESH_PER_AND=3, NUM_AND=4, LATENCY=8, and the FSM state enum.
REQ-029 SHALL instantiate existing and_HPC2 (security_order 2) four times; the control FSM SHALL be a single sub-module sbox_inv_ctrl_fsm.

Verification
REQ-030 Reset, then SI shares {0x5,0xA,0xF} (x=0x0) with random Fresh -> out_valid 8 cycles later, XOR of SO shares = 0x3, Synch pulses once.
REQ-031 Sweep x=0x0..0xF with random share splits and Fresh -> XOR of SO shares matches S4inv for all 16 values, e.g. 0xC->0x0, 0xF->0xF, 0x6->0x1.
REQ-032 Hold out_ready=0 for 5 cycles in DONE -> SO stable, out_valid=1, Synch high only on the first cycle; out_ready=1 -> IDLE on the next edge.
REQ-033 Toggle in_valid with varied SI values during BUSY -> output still equals S4inv of the first accepted value; in_ready=0 throughout.
REQ-034 Pull rst low at BUSY cycle 4 -> outputs 0 immediately; after release, new x=0x8 -> result 0x9 after exactly 8 cycles.
REQ-035 Probe test with a glitch-extended model of d=2 and fixed x versus random x over 1e6 traces -> no first- or second-order leakage detected.
